// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- multi-cycle instruction sequencer for simple_cpu.
//
// Fetches an 8-bit opcode, decodes it and steps the datapath through
// IDLE -> FETCH -> DECODE -> EXEC/MEM, using ready-based wait states on
// the instruction and data memories.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   run          level; high allows the next instruction fetch
//   instr[7:0]   opcode from instruction memory (valid with imem_ready)
//   imem_ready   instruction-memory data valid
//   dmem_ready   data-memory access complete
//   imem_req     instruction fetch request
//   ir_load      opcode capture strobe (same cycle as imem_ready)
//   pc_inc       PC += 1 strobe
//   pc_load      PC <= jump target strobe
//   alu_control  one-hot ALU op: 0001/0010/0100/1000 for opcodes 03..06
//   acc_load     accumulator write strobe
//   rd_dmem      data-memory read
//   wr_dmem      data-memory write
//   busy         high in every state except IDLE and HALT
//   halted       high in HALT
//   timeout      sticky watchdog flag
//
// Parameter WAIT_LIMIT (1..255): wait cycles allowed in FETCH or MEM
// before the watchdog halts the sequencer.
//
// Build option: define SEQ_WATCHDOG_EN to compile in the wait watchdog.
// Without it waits are unbounded and timeout is tied to 0.

module cpu_sequencer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] instr,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [3:0] alu_control,
    output logic       acc_load,
    output logic       rd_dmem,
    output logic       wr_dmem,
    output logic       busy,
    output logic       halted,
    output logic       timeout
);

    if (WAIT_LIMIT == 0 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
        $error("cpu_sequencer: WAIT_LIMIT must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] op;
    logic       wait_expired;

    // Opcode classes used by both decode and execute.
    logic op_is_mem;
    logic op_is_exec;
    logic op_is_halt;
    logic op_is_nop;

    assign op_is_mem  = (op == 8'h00) || (op == 8'h01);
    assign op_is_exec = (op >= 8'h02) && (op <= 8'h06);
    assign op_is_halt = (op == 8'hFF);
    assign op_is_nop  = !(op_is_mem || op_is_exec || op_is_halt);

    // ------------------------------------------------------------------
    // State and opcode registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op <= 8'h00;
        end else if (state == S_FETCH && imem_ready) begin
            op <= instr;
        end
    end

    // ------------------------------------------------------------------
    // Optional wait watchdog
    // ------------------------------------------------------------------
`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] WAIT_LIMIT_Q = 8'(WAIT_LIMIT);

    logic [7:0] wait_cnt;
    logic       waiting;

    assign waiting      = (state == S_FETCH && !imem_ready) ||
                          (state == S_MEM   && !dmem_ready);
    // A ready arriving on the limit cycle makes waiting low, so it wins.
    assign wait_expired = waiting && (wait_cnt == WAIT_LIMIT_Q);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            // Clear on entry so every FETCH/MEM visit gets a fresh budget.
            if (state_next != state &&
                (state_next == S_FETCH || state_next == S_MEM)) begin
                wait_cnt <= 8'd0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_expired) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready)        state_next = S_DECODE;
                else if (wait_expired) state_next = S_HALT;
            end
            S_DECODE: begin
                if (op_is_mem)       state_next = S_MEM;
                else if (op_is_exec) state_next = S_EXEC;
                else if (op_is_halt) state_next = S_HALT;
                else                 state_next = run ? S_FETCH : S_IDLE;
            end
            S_EXEC: begin
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_MEM: begin
                if (dmem_ready)        state_next = run ? S_FETCH : S_IDLE;
                else if (wait_expired) state_next = S_HALT;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (ir_load and the MEM completion strobes are Mealy)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_control = 4'b0000;
        acc_load    = 1'b0;
        rd_dmem     = 1'b0;
        wr_dmem     = 1'b0;
        busy        = (state != S_IDLE) && (state != S_HALT);
        halted      = (state == S_HALT);
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            S_DECODE: begin
                pc_inc = op_is_nop;
            end
            S_EXEC: begin
                case (op)
                    8'h02: pc_load = 1'b1;
                    8'h03: alu_control = 4'b0001;
                    8'h04: alu_control = 4'b0010;
                    8'h05: alu_control = 4'b0100;
                    8'h06: alu_control = 4'b1000;
                    default: ;
                endcase
                if (op >= 8'h03 && op <= 8'h06) begin
                    acc_load = 1'b1;
                    pc_inc   = 1'b1;
                end
            end
            S_MEM: begin
                // Strobe held through the completing cycle.
                rd_dmem = (op == 8'h00);
                wr_dmem = (op == 8'h01);
                if (dmem_ready) begin
                    pc_inc   = 1'b1;
                    acc_load = (op == 8'h00);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for simple_cpu. Fetches an 8-bit opcode from instruction memory, decodes it, and drives the PC, accumulator, ALU and data-memory strobes over a fixed state sequence with ready-based wait states. Sits between the instruction/data memories and the datapath, and supersedes direct combinational opcode decode for timing-controlled execution.

## Interface
Parameters:
- WAIT_LIMIT, 16: maximum wait cycles in FETCH or MEM before a timeout (used only with the watchdog compiled in); legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; high allows fetching of the next instruction
- instr  in  8  opcode from instruction memory, valid when imem_ready is high
- imem_ready  in  1  instruction-memory data valid
- dmem_ready  in  1  data-memory access complete
- imem_req  out  1  instruction fetch request
- ir_load  out  1  opcode capture strobe
- pc_inc  out  1  PC += 1 strobe
- pc_load  out  1  PC <= jump target strobe
- alu_control  out  4  one-hot ALU op: 0001/0010/0100/1000 for opcodes 03/04/05/06
- acc_load  out  1  accumulator write strobe
- rd_dmem  out  1  data-memory read
- wr_dmem  out  1  data-memory write
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- timeout  out  1  sticky watchdog flag

## Operation
- The decision is stored in an internal 8-bit opcode register, `op`. The states are IDLE, FETCH, DECODE, EXEC, MEM and HALT.
- Reset:
  - The state goes to IDLE and `op` to 0x00.
  - All outputs are 0 on the cycle after rst is sampled high.
  - rst overrides any state, including mid-access. rd_dmem, wr_dmem and imem_req drop immediately after reset.
- IDLE: all outputs are 0. If run=1, go to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_load=1 in the same cycle (Mealy), `op`<=instr, and the next state is DECODE.
  - Otherwise stay in FETCH.
  - run is ignored once FETCH has been entered.
- DECODE: one cycle, all strobes 0. Next state by `op`:
  - 0x00 or 0x01 -> MEM.
  - 0x02 through 0x06 -> EXEC.
  - 0xFF -> HALT.
  - Any other value is a NOP: pc_inc=1 this cycle, and the next state is FETCH if run=1, else IDLE.
- EXEC: one cycle.
  - 0x02: pc_load=1.
  - 0x03 to 0x06: alu_control is the one-hot code, acc_load=1 and pc_inc=1.
  - alu_control is 0000 in every other state and cycle.
  - Next state is FETCH if run=1, else IDLE.
- MEM:
  - rd_dmem=1 (op 0x00) or wr_dmem=1 (op 0x01), held every cycle until dmem_ready=1.
  - On dmem_ready=1: pc_inc=1, plus acc_load=1 for 0x00. The strobe is still asserted that cycle.
  - Next state is FETCH if run=1, else IDLE.
- HALT: halted=1 and all strobes 0. Only rst exits HALT.
- At most one of pc_inc and pc_load is high in any cycle. rd_dmem and wr_dmem are never high together.

## Timing
- Zero-wait latency (imem_ready and dmem_ready high on the first cycle), with run held at 1:
  - ALU, jump, load and store: 3 cycles per instruction (FETCH, DECODE, EXEC/MEM).
  - NOP: 2 cycles.
- Each wait cycle adds exactly 1 cycle.
- From IDLE to the first imem_req: 1 cycle after run is sampled high.
- A ready input that is high outside its wait state is ignored.
- Handshake: the request or strobe is held constant until ready is sampled high. It deasserts on the following cycle.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments on each cycle in which ready is low.
  - If ready is still low when the counter equals WAIT_LIMIT, the next state is HALT and timeout<=1.
  - timeout stays at 1 until rst.
  - A ready arriving in the same cycle as the limit wins: the access completes and there is no timeout.
- SEQ_WATCHDOG_EN undefined: there is no counter, waits are unbounded, and timeout is tied to 0.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 2 cycles during MEM with op 0x01, then run=0.
  - Required: next cycle wr_dmem=0, all outputs 0, busy=0; the block stays in IDLE.
- ALU stream:
  - Stimulus: run=1, zero-wait memories, instr sequence 03, 04, 05, 06.
  - Required: alu_control 0001, 0010, 0100, 1000 on cycles 3, 6, 9, 12, each with acc_load=1 and pc_inc=1.
- Load with waits:
  - Stimulus: instr 0x00, dmem_ready low for 3 cycles in MEM.
  - Required: rd_dmem high for 4 cycles; acc_load and pc_inc pulse only on the 4th.
- Jump, NOP, halt:
  - Stimulus: instr sequence 02, 7A, FF.
  - Required: pc_load pulses once; pc_inc pulses in DECODE for 0x7A; then halted=1 persists with run=1 until rst.
- Watchdog (with SEQ_WATCHDOG_EN, WAIT_LIMIT=4):
  - Stimulus: imem_ready held low.
  - Required: HALT entered with timeout=1.
  - Repeat with imem_ready=1 on the limit cycle: required normal DECODE, timeout=0.
